// File: rtl/arm_pkg.sv
// Shared definitions for the multiplier: FSM state encoding, latency and
// the decoder funct bit positions that select long/signed multiplies.
package arm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mult_state_t;

  localparam int MUL_WIDTH        = 32;
  localparam int MUL_LATENCY      = MUL_WIDTH + 1;
  localparam int FUNCT_MUL_LONG   = 3;
  localparam int FUNCT_MUL_SIGNED = 2;

endpackage

// File: rtl/mult_unit.sv
// Iterative shift-add multiplier for MUL / UMULL / SMULL. One multiplier bit
// per cycle, fixed WIDTH+1 latency from start to the done pulse.
module mult_unit
  import arm_pkg::*;
#(
  parameter int WIDTH = MUL_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             long_mul,
  input  logic             signed_mul,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result_lo,
  output logic [WIDTH-1:0] result_hi,
  output logic             flag_n,
  output logic             flag_z
);

  localparam int CW = $clog2(WIDTH) + 1;

  mult_state_t        state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic               long_q, long_d;
  logic               neg_q, neg_d;
  logic [WIDTH-1:0]   res_lo_q, res_lo_d;
  logic [WIDTH-1:0]   res_hi_q, res_hi_d;
  logic               flag_n_q, flag_n_d;
  logic               flag_z_q, flag_z_d;

  logic               sign_fix;
  logic [WIDTH-1:0]   a_abs, b_abs;
  logic [2*WIDTH-1:0] acc_sum;
  logic [2*WIDTH-1:0] prod;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    long_d   = long_q;
    neg_d    = neg_q;
    res_lo_d = res_lo_q;
    res_hi_d = res_hi_q;
    flag_n_d = flag_n_q;
    flag_z_d = flag_z_q;

    // Magnitudes are taken unsigned, so abs(most-negative) reads as 2^(WIDTH-1).
    sign_fix = signed_mul & long_mul;
    a_abs    = (sign_fix && src_a[WIDTH-1]) ? (~src_a + 1'b1) : src_a;
    b_abs    = (sign_fix && src_b[WIDTH-1]) ? (~src_b + 1'b1) : src_b;

    acc_sum  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
    prod     = neg_q ? (~acc_sum + 1'b1) : acc_sum;

    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d  = BUSY;
          cnt_d    = '0;
          acc_d    = '0;
          mcand_d  = {{WIDTH{1'b0}}, a_abs};
          mplier_d = b_abs;
          long_d   = long_mul;
          neg_d    = sign_fix & (src_a[WIDTH-1] ^ src_b[WIDTH-1]);
        end else if (state_q == DONE) begin
          state_d = IDLE;
        end
      end
      BUSY: begin
        acc_d    = acc_sum;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d  = DONE;
          res_lo_d = prod[WIDTH-1:0];
          res_hi_d = long_q ? prod[2*WIDTH-1:WIDTH] : '0;
          flag_n_d = long_q ? prod[2*WIDTH-1] : prod[WIDTH-1];
          flag_z_d = long_q ? (prod == '0) : (prod[WIDTH-1:0] == '0);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      long_q   <= 1'b0;
      neg_q    <= 1'b0;
      res_lo_q <= '0;
      res_hi_q <= '0;
      flag_n_q <= 1'b0;
      flag_z_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      long_q   <= long_d;
      neg_q    <= neg_d;
      res_lo_q <= res_lo_d;
      res_hi_q <= res_hi_d;
      flag_n_q <= flag_n_d;
      flag_z_q <= flag_z_d;
    end
  end

  assign busy      = (state_q == BUSY);
  assign done      = (state_q == DONE);
  assign result_lo = res_lo_q;
  assign result_hi = res_hi_q;
  assign flag_n    = flag_n_q;
  assign flag_z    = flag_z_q;

endmodule

// File: tb/tb_mult_unit.sv
// Directed bench for mult_unit: expected products are pushed to a scoreboard
// at launch and popped when done pulses.
module tb_mult_unit;

  logic        clk;
  logic        reset;
  logic        start;
  logic        long_mul;
  logic        signed_mul;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic        done;
  logic [31:0] result_lo;
  logic [31:0] result_hi;
  logic        flag_n;
  logic        flag_z;

  typedef struct {
    logic [31:0] lo;
    logic [31:0] hi;
    logic        n;
    logic        z;
  } exp_t;

  exp_t scb[$];
  int   checks = 0;
  int   errors = 0;

  mult_unit #(.WIDTH(32)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .long_mul   (long_mul),
    .signed_mul (signed_mul),
    .src_a      (src_a),
    .src_b      (src_b),
    .busy       (busy),
    .done       (done),
    .result_lo  (result_lo),
    .result_hi  (result_hi),
    .flag_n     (flag_n),
    .flag_z     (flag_z)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                 input logic l, input logic s);
    exp_t        e;
    logic [63:0] p;
    longint      sa, sb;
    logic [31:0] lo32;
    if (l && s) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      p  = 64'(sa * sb);
    end else if (l) begin
      p = {32'b0, a} * {32'b0, b};
    end else begin
      lo32 = a * b;
      p    = {32'b0, lo32};
    end
    e.lo = p[31:0];
    e.hi = p[63:32];
    e.n  = l ? p[63] : p[31];
    e.z  = l ? (p == 64'd0) : (p[31:0] == 32'd0);
    return e;
  endfunction

  // Drive a request at the current negedge and record its expected result.
  task automatic launch(input logic [31:0] a, input logic [31:0] b,
                        input logic l, input logic s);
    scb.push_back(model(a, b, l, s));
    src_a      = a;
    src_b      = b;
    long_mul   = l;
    signed_mul = s;
    start      = 1'b1;
    $display("launch a=%h b=%h long=%0b signed=%0b", a, b, l, s);
  endtask

  // Returns at the negedge of the done cycle. With hold set, start stays high
  // through BUSY and the operands are scrambled to prove they were latched.
  task automatic wait_done(input string tag, input bit hold);
    int   lat;
    int   busy_cnt;
    bit   got;
    exp_t e;
    lat = 0;
    busy_cnt = 0;
    got = 1'b0;
    for (int k = 1; k <= 40 && !got; k++) begin
      @(negedge clk);
      if (k == 1) begin
        if (hold) begin
          src_a = ~src_a;
          src_b = ~src_b;
        end else begin
          start = 1'b0;
        end
      end
      if (busy) busy_cnt++;
      if (done) begin
        got = 1'b1;
        lat = k;
      end
    end
    start = 1'b0;
    check({tag, "_latency"}, 64'(lat), 64'(33));
    check({tag, "_busy_cycles"}, 64'(busy_cnt), 64'(32));
    checks++;
    assert (scb.size() > 0)
    else begin
      errors++;
      $error("FAIL %s_scoreboard: observed empty expected entry", tag);
    end
    if (scb.size() > 0) begin
      e = scb.pop_front();
      check({tag, "_lo"}, 64'(result_lo), 64'(e.lo));
      check({tag, "_hi"}, 64'(result_hi), 64'(e.hi));
      check({tag, "_n"}, 64'(flag_n), 64'(e.n));
      check({tag, "_z"}, 64'(flag_z), 64'(e.z));
      $display("%s done lat=%0d lo=%h hi=%h n=%0b z=%0b", tag, lat, result_lo, result_hi, flag_n, flag_z);
    end
  endtask

  // One idle cycle: done must have dropped and results must hold.
  task automatic idle_check(input string tag);
    logic [31:0] lo_prev, hi_prev;
    lo_prev = result_lo;
    hi_prev = result_hi;
    @(negedge clk);
    check({tag, "_done_pulse"}, 64'(done), 64'd0);
    check({tag, "_idle_busy"}, 64'(busy), 64'd0);
    check({tag, "_hold_lo"}, 64'(result_lo), 64'(lo_prev));
    check({tag, "_hold_hi"}, 64'(result_hi), 64'(hi_prev));
  endtask

  task automatic no_done_window(input string tag);
    int n_done;
    n_done = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (done) n_done++;
    end
    check({tag, "_no_done"}, 64'(n_done), 64'd0);
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    long_mul   = 1'b0;
    signed_mul = 1'b0;
    src_a      = '0;
    src_b      = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_lo", 64'(result_lo), 64'd0);
    check("rst_hi", 64'(result_hi), 64'd0);
    check("rst_n", 64'(flag_n), 64'd0);
    check("rst_z", 64'(flag_z), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    launch(32'd7, 32'd6, 1'b0, 1'b0);
    wait_done("mul_7x6", 1'b0);
    idle_check("mul_7x6");

    launch(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0);
    wait_done("umull_max", 1'b0);
    idle_check("umull_max");

    launch(32'hFFFF_FFFE, 32'd3, 1'b1, 1'b1);
    wait_done("smull_m2x3", 1'b0);
    idle_check("smull_m2x3");

    launch(32'h8000_0000, 32'h8000_0000, 1'b1, 1'b1);
    wait_done("smull_minmin", 1'b0);
    idle_check("smull_minmin");

    launch(32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1);
    wait_done("mul_signed_ignored", 1'b0);
    idle_check("mul_signed_ignored");

    launch(32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 1'b0);
    wait_done("umull_mixed", 1'b0);
    idle_check("umull_mixed");

    // Zero product, then a new request issued in the DONE cycle.
    launch(32'd0, 32'd5, 1'b0, 1'b0);
    wait_done("mul_zero", 1'b0);
    launch(32'd3, 32'd4, 1'b0, 1'b0);
    wait_done("mul_b2b", 1'b0);
    idle_check("mul_b2b");

    launch(32'd11, 32'd13, 1'b1, 1'b1);
    wait_done("start_held", 1'b1);
    no_done_window("start_held");

    // Reset in the tenth BUSY cycle aborts the operation.
    src_a      = 32'd9;
    src_b      = 32'd9;
    long_mul   = 1'b1;
    signed_mul = 1'b0;
    start      = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    check("mid_reset_was_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_reset_busy", 64'(busy), 64'd0);
    check("mid_reset_done", 64'(done), 64'd0);
    check("mid_reset_lo", 64'(result_lo), 64'd0);
    check("mid_reset_hi", 64'(result_hi), 64'd0);
    check("mid_reset_n", 64'(flag_n), 64'd0);
    check("mid_reset_z", 64'(flag_z), 64'd0);
    $display("mid_reset busy=%0b done=%0b lo=%h hi=%h", busy, done, result_lo, result_hi);
    no_done_window("mid_reset");

    // Reset wins over a simultaneous start.
    reset = 1'b1;
    start = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    check("rst_vs_start_busy", 64'(busy), 64'd0);
    @(negedge clk);
    check("rst_vs_start_busy2", 64'(busy), 64'd0);
    $display("reset_vs_start busy=%0b", busy);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_unit.md
Name: mult_unit

Overview:
- Iterative shift-add multiplier that executes MUL, UMULL and SMULL.
- Sits downstream of the main decoder. It is started when the decoder's mult control is asserted.
  - The long flag comes from funct[3]; the signed flag comes from funct[2].
  - The reg_w1 write path (Rd / RdHi) and the reg_w3 write path (RdLo) consume result_hi/result_lo when done pulses.
- busy is used by the hazard/stall logic to freeze fetch/decode while a multiply is in flight.

Parameters:
- WIDTH, 32, operand width in bits. The product is 2*WIDTH bits.

Ports:
- clk  input  1  system clock, rising-edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request a multiply. Sampled only in IDLE or DONE.
- long_mul  input  1  1 = 64-bit result (UMULL/SMULL); 0 = 32-bit MUL.
- signed_mul  input  1  1 = two's-complement operands (SMULL). Ignored when long_mul=0.
- src_a  input  WIDTH  multiplicand (Rn).
- src_b  input  WIDTH  multiplier (Rm).
- busy  output  1  high while the iteration is in progress.
- done  output  1  one-cycle pulse; results are valid from this cycle.
- result_lo  output  WIDTH  low half of the product.
- result_hi  output  WIDTH  high half of the product; 0 when long_mul=0.
- flag_n  output  1  sign of the result: result_hi[WIDTH-1] if long, else result_lo[WIDTH-1].
- flag_z  output  1  1 if the whole result is zero (64-bit if long, 32-bit otherwise).

Behaviour:
- Reset: state=IDLE; busy=0, done=0, result_lo=0, result_hi=0, flag_n=0, flag_z=0; iteration counter=0.
- FSM states: IDLE, BUSY, DONE.
  - IDLE: start=1 -> BUSY.
  - BUSY: after WIDTH iterations -> DONE.
  - DONE: start=1 -> BUSY (back-to-back accepted); else -> IDLE.
- Start capture, on the edge where start is accepted:
  - Latch the operands, long_mul and signed_mul.
  - Clear the accumulator and counter.
  - If signed_mul&long_mul, latch |src_a| and |src_b|, and latch neg = src_a[MSB]^src_b[MSB]. Otherwise neg=0.
- BUSY: one multiplier bit per cycle, LSB first.
  - If the current bit is 1, add the shifted multiplicand into the 2*WIDTH-bit accumulator.
  - Counter increments; exit after WIDTH BUSY cycles.
- Timing: start high in cycle 0 -> busy=1 in cycles 1..WIDTH -> done=1 in cycle WIDTH+1 only.
  - Fixed latency WIDTH+1; no early termination.
- Result write, on the BUSY->DONE edge:
  - Write result_lo/hi from the accumulator, two's-complement negated if neg.
  - Zero result_hi if !long_mul.
  - Compute flags from the final result.
- Results and flags hold their values until the next result write; they are not cleared in IDLE.
- Edge cases:
  - start while BUSY: ignored. The operation in flight is not disturbed, and no second done is produced.
  - Abs of the most negative value (0x80000000) is treated as the unsigned 2^31, giving the correct signed product.
  - long_mul=0: result_lo = low WIDTH bits of the product; signed and unsigned give identical results.
  - reset asserted mid-BUSY: next cycle is IDLE with all outputs at reset values; no done pulse.
  - reset and start in the same cycle: reset wins.

Decomposition:
- Shared package (arm_pkg):
  - mult_state_t enum {IDLE, BUSY, DONE}.
  - MUL_LATENCY = WIDTH+1 constant.
  - The funct bit indices FUNCT_MUL_LONG=3 and FUNCT_MUL_SIGNED=2.
- No sub-module: the FSM, datapath and sign fix-up are a single block.

Test Plan:
- MUL: start with src_a=7, src_b=6, long=0 -> done exactly 33 cycles after start; result_lo=42, result_hi=0, n=0, z=0. busy is high for exactly 32 cycles.
- UMULL: src_a=src_b=0xFFFFFFFF, long=1, signed=0 -> result_hi=0xFFFFFFFE, result_lo=0x00000001, n=1, z=0.
- SMULL signs:
  - src_a=0xFFFFFFFE (-2), src_b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFFA, n=1.
  - src_a=src_b=0x80000000 -> hi=0x40000000, lo=0, n=0.
- Zero / back-to-back:
  - MUL 0*5 -> z=1, n=0.
  - Then start in the DONE cycle with 3*4 -> the second done comes 33 cycles later with lo=12.
- start held high during BUSY -> ignored: exactly one done, and the result comes from the first operands.
- Reset at cycle 10 of BUSY -> busy=0, done=0, results=0 the next cycle; no done pulse within 40 cycles.
